cla_serial_sequencer: RTL
=========================

// Module: cla_serial_sequencer
// PURPOSE
// - Sequences one shared 4-bit carry_look_adder slice to add/subtract WIDTH-bit operands, 4 bits per cycle, LSB first.
// - Registers the inter-slice carry between cycles.
// - Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
// - One operation in flight at a time.
// PARAMETERS
// WIDTH  16  operand/result width; must be a multiple of 4 and >= 8
// PORTS
// clk        in   1      clock, rising edge
// rst        in   1      reset, synchronous, active-high
// in_valid   in   1      operands and op_sub are valid
// in_ready   out  1      block can accept an operation (IDLE only)
// op_a       in   WIDTH  operand A
// op_b       in   WIDTH  operand B
// op_sub     in   1      0: A+B; 1: A-B
// out_valid  out  1      sum, carry_out and overflow are valid
// out_ready  in   1      consumer takes the result
// sum        out  WIDTH  result, modulo 2^WIDTH
// carry_out  out  1      carry out of MSB; on subtract, 1 = no borrow
// overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, slice counter=0, internal regs=0.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
// - IDLE
//   - in_ready=1.
//   - On in_valid && in_ready: latch a_sh=op_a, b_sh = op_sub ? ~op_b : op_b, carry=op_sub, cnt=0.
//   - Also latch a_msb=op_a[WIDTH-1] and b_msb = MSB of b_sh. Go to RUN.
// - RUN (exactly WIDTH/4 cycles)
//   - The slice adds a_sh[3:0] + b_sh[3:0] + carry.
//   - Each cycle: sum_sh <= {slice_sum, sum_sh[WIDTH-1:4]}; a_sh and b_sh shift right by 4; carry <= slice_cout; cnt++.
//   - When cnt == WIDTH/4-1, go to DONE.
//   - in_ready=0; in_valid is ignored.
// - DONE
//   - out_valid=1. sum=sum_sh, carry_out=carry.
//   - overflow = (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb).
//   - Outputs hold stable while out_ready=0.
//   - On out_ready: go to IDLE, out_valid drops next cycle, and sum/carry_out/overflow keep their last values.
// - Latency: out_valid rises WIDTH/4 clocks after the accepting edge (4 for WIDTH=16).
// - Throughput: one operation per WIDTH/4+2 cycles at best; no accept in the same cycle as result handoff.
// - All arithmetic is modulo 2^WIDTH; the slice counter width is clog2(WIDTH/4), with a minimum of 1.
// - Reset mid-RUN or mid-DONE: rst wins over any handshake that cycle; the operation is discarded and outputs return to reset values.
// - Output regs are driven only in DONE entry; no combinational path from in_* to out_*.
// STRUCTURE
// - Shared package cla_seq_pkg:
//   - state enum {IDLE, RUN, DONE} (2-bit encoding);
//   - SLICE_W=4 localparam;
//   - function for the slice counter width.
// - One sub-module: carry_look_adder (existing 4-bit CLA: a[3:0], b[3:0], cin, sum[3:0], cout), instantiated once.
// - Everything else is flat in cla_serial_sequencer: FSM, counter, shift registers, carry register, output registers.
// TESTING (WIDTH=16)
// - Add 0x1234+0x0FCD, op_sub=0 -> after 4 clocks out_valid=1, sum=0x2201, carry_out=0, overflow=0.
// - Wrap 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, overflow=0.
// - Signed 0x7FFF+0x0001 -> sum=0x8000, overflow=1.
// - Sub 0x0005-0x0007 -> sum=0xFFFE, carry_out=0, overflow=0.
// - Sub 0x8000-0x0001 -> sum=0x7FFF, overflow=1.
// - Backpressure and ignored input:
//   - hold out_ready=0 for 5 cycles -> outputs constant, in_ready=0 throughout;
//   - raise out_ready -> next cycle in_ready=1;
//   - in_valid pulsed during RUN is ignored.
// - Reset in 2nd RUN cycle:
//   - pulse rst -> next cycle IDLE, in_ready=1, out_valid=0, sum=0;
//   - then 0x0001+0x0001 -> sum=0x0002.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the serial carry-lookahead sequencer.
// - SliceW    : width of the shared adder slice.
// - state_e   : sequencer FSM states.
// - cnt_width : width of the slice counter for a given operand width.
package cla_seq_pkg;

  localparam int unsigned SliceW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // clog2 of the slice count, but never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width / SliceW);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/carry_look_adder.sv
// 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
module carry_look_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/cla_serial_sequencer.sv
// Adds or subtracts WIDTH-bit operands through one shared 4-bit CLA slice,
// one slice per cycle, LSB first, carrying between slices in a register.
// Ports:
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  : operand handshake; ready only while idle
//   op_a, op_b, op_sub   : operands; op_sub=1 selects A-B
//   out_valid / out_ready: result handshake
//   sum                  : result modulo 2^WIDTH
//   carry_out            : carry out of the MSB (on subtract, 1 = no borrow)
//   overflow             : two's-complement signed overflow
module cla_serial_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned Slices = WIDTH / SliceW;
  localparam int unsigned CntW   = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(Slices - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic [SliceW-1:0]  slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_sh_next;

  carry_look_adder u_cla (
    .a    (a_sh_q[SliceW-1:0]),
    .b    (b_sh_q[SliceW-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice enters at the top so after all slices the LSB slice lands at bit 0.
  assign sum_sh_next = {slice_sum, sum_sh_q[WIDTH-1:SliceW]};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
          a_sh_d  = op_a;
          b_sh_d  = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          cnt_d   = '0;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
          state_d = StRun;
        end
      end
      StRun: begin
        sum_sh_d = sum_sh_next;
        a_sh_d   = a_sh_q >> SliceW;
        b_sh_d   = b_sh_q >> SliceW;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          sum_d       = sum_sh_next;
          carry_out_d = slice_cout;
          overflow_d  = (a_msb_q == b_msb_q) && (slice_sum[SliceW-1] != a_msb_q);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
